// File: rtl/prog_mem.sv
// Loadable program memory for the CPU fetch path: registered read port, streaming
// load port from address 0, and a post-reset clear pass that fills memory with HLT.
module prog_mem #(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 4,
  parameter logic [DATA_W-1:0] INIT_WORD = 8'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              handshake;
  logic              rd_fire;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign handshake = (state_q == ST_LOAD) && load_valid;
  assign rd_fire   = (state_q == ST_RUN) && rd_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      ptr_q        <= '0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
    end
  end

  // Next-state logic, including the single memory write port shared by CLEAR and LOAD
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    wr_en        = 1'b0;
    wr_addr      = ptr_q;
    wr_data      = INIT_WORD;
    case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        if (ptr_q == PTR_MAX) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_d      = ST_LOAD;
          ptr_d        = '0;
          load_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          wr_en   = 1'b1;
          wr_data = load_data;
          if (load_count_q != COUNT_MAX) begin
            load_count_d = load_count_q + 1'b1;
          end
          // Pointer holds at the top word rather than wrapping onto the program start
          if (ptr_q != PTR_MAX) begin
            ptr_d = ptr_q + 1'b1;
          end
          if (load_last || (ptr_q == PTR_MAX)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state_q != ST_RUN);
    load_ready = (state_q == ST_LOAD);
  end

  // Memory array kept reset-free so it maps onto block RAM; reset suppresses writes
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= mem_q[rd_addr];
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign load_count = load_count_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem (DATA_W=8, ADDR_W=4): clear pass, loads, stalls,
// auto-finish, read/load overlap and reset abort.
module tb_prog_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [4:0] load_count;
  logic       busy;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  prog_mem #(.DATA_W(8), .ADDR_W(4), .INIT_WORD(8'hF0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_count (load_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (busy && cnt < 100) begin
      step();
      cnt++;
    end
    check(tag, cnt, 16);
  endtask

  task automatic read_chk(input logic [3:0] addr, input logic [7:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = addr;
    step();
    rd_en = 1'b0;
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_data"}, rd_data, exp);
  endtask

  task automatic load_word(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_addr = '0; load_start = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;

    // 1: reset values, clear duration, back-to-back reads of HLT
    step();
    rst = 1'b0;
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_count", load_count, 0);
    check("rst_busy", busy, 1);
    wait_clear("clear_cycles");
    for (int a = 0; a < 16; a++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      step();
      check($sformatf("clr_rd%0d_valid", a), rd_valid, 1);
      check($sformatf("clr_rd%0d_data", a), rd_data, 8'hF0);
    end
    rd_en = 1'b0;
    step();
    check("rd_idle_valid", rd_valid, 0);
    check("rd_idle_hold", rd_data, 8'hF0);

    // 2: short load terminated by load_last
    start_load();
    check("t2_ready", load_ready, 1);
    check("t2_busy", busy, 1);
    load_word(8'h15, 1'b0);
    load_word(8'h71, 1'b0);
    load_word(8'hB0, 1'b1);
    check("t2_count", load_count, 3);
    check("t2_busy_low", busy, 0);
    check("t2_ready_low", load_ready, 0);
    read_chk(4'd0, 8'h15, "t2_a0");
    read_chk(4'd1, 8'h71, "t2_a1");
    read_chk(4'd2, 8'hB0, "t2_a2");
    read_chk(4'd3, 8'hF0, "t2_a3");

    // 3: full-depth load auto-finishes; a 17th word is refused
    start_load();
    for (int i = 0; i < 16; i++) begin
      load_word(8'(i), 1'b0);
    end
    check("t3_count", load_count, 16);
    check("t3_ready_low", load_ready, 0);
    load_valid = 1'b1;
    load_data  = 8'hEE;
    step();
    check("t3_extra_ready", load_ready, 0);
    check("t3_extra_count", load_count, 16);
    load_valid = 1'b0;
    read_chk(4'd15, 8'h0F, "t3_a15");
    read_chk(4'd0, 8'h00, "t3_a0");

    // 4: stalled load; reads during LOAD are blocked
    start_load();
    load_word(8'hA1, 1'b0);
    rd_en = 1'b1; rd_addr = 4'd0;
    step();
    check("t4_blocked1", rd_valid, 0);
    step();
    check("t4_blocked2", rd_valid, 0);
    check("t4_mid_count", load_count, 1);
    rd_en = 1'b0;
    load_word(8'hA2, 1'b1);
    check("t4_count", load_count, 2);
    check("t4_busy_low", busy, 0);
    read_chk(4'd0, 8'hA1, "t4_a0");
    read_chk(4'd1, 8'hA2, "t4_a1");
    read_chk(4'd2, 8'h02, "t4_a2");

    // 5: read and load_start in the same RUN cycle
    rd_en = 1'b1; rd_addr = 4'd1; load_start = 1'b1;
    step();
    rd_en = 1'b0; load_start = 1'b0;
    check("t5_valid", rd_valid, 1);
    check("t5_data", rd_data, 8'hA2);
    check("t5_in_load", load_ready, 1);
    check("t5_count_clr", load_count, 0);

    // 6: reset mid-load aborts and restarts the clear pass
    load_word(8'h33, 1'b0);
    load_word(8'h44, 1'b0);
    check("t6_pre_count", load_count, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_count", load_count, 0);
    check("t6_rst_data", rd_data, 0);
    check("t6_rst_ready", load_ready, 0);
    wait_clear("t6_clear_cycles");
    for (int a = 0; a < 16; a++) begin
      read_chk(4'(a), 8'hF0, $sformatf("t6_a%0d", a));
    end
    check("t6_count_end", load_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
